ysyx_23060025_store_queue: RTL and testbench

//  In-order store queue between the LSU store port and the AXI write buffer. Accepts byte/half/word stores,

---
 rtl/ysyx_23060025_store_queue_if.sv | 38 +++
 rtl/ysyx_23060025_store_queue.sv | 172 +++++++++++++++++
 tb/tb_ysyx_23060025_store_queue.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060025_store_queue_if.sv
// Signal bundle between the LSU store port, the store queue and the AXI write buffer.
// The queue uses the slave view; the LSU/write-buffer side uses the master view.
`timescale 1ns/1ps
`ifndef MACRO_CACHE_LINE_OFF_ADDR_W
`define MACRO_CACHE_LINE_OFF_ADDR_W 4
`endif

interface ysyx_23060025_store_queue_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int CACHE_LINE_W = (2 ** `MACRO_CACHE_LINE_OFF_ADDR_W) * 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [ADDR_WIDTH-1:0]   in_addr;
    logic [DATA_WIDTH-1:0]   in_data;
    logic [3:0]              in_strb;
    logic [2:0]              in_type;
    logic [ADDR_WIDTH-1:0]   ld_addr;
    logic                    ld_hit;
    logic                    sq_idle;
    logic                    out_pwr_req;
    logic [ADDR_WIDTH-1:0]   out_pwaddr;
    logic [CACHE_LINE_W-1:0] out_pwdata;
    logic [3:0]              out_pwstrb;
    logic [2:0]              out_pwtype;
    logic                    out_pwrdy;

    modport master (
        output in_valid, in_addr, in_data, in_strb, in_type, ld_addr, out_pwrdy,
        input  in_ready, ld_hit, sq_idle, out_pwr_req, out_pwaddr, out_pwdata, out_pwstrb, out_pwtype
    );

    modport slave (
        input  in_valid, in_addr, in_data, in_strb, in_type, ld_addr, out_pwrdy,
        output in_ready, ld_hit, sq_idle, out_pwr_req, out_pwaddr, out_pwdata, out_pwstrb, out_pwtype
    );
endinterface

// File: rtl/ysyx_23060025_store_queue.sv
// In-order store queue feeding the AXI write buffer one store per out_pwrdy window.
// Define YSYX_23060025_STQ_MERGE_EN to coalesce stores into the youngest entry of the same word.
`timescale 1ns/1ps
`ifndef MACRO_CACHE_LINE_OFF_ADDR_W
`define MACRO_CACHE_LINE_OFF_ADDR_W 4
`endif

module ysyx_23060025_store_queue #(
    parameter int ADDR_WIDTH            = 32,
    parameter int DATA_WIDTH            = 32,
    parameter int CACHE_LINE_OFF_ADDR_W = `MACRO_CACHE_LINE_OFF_ADDR_W,
    parameter int STQ_DEPTH             = 4
) (
    input logic                        clock,
    input logic                        reset,
    ysyx_23060025_store_queue_if.slave sq
);
    localparam int CACHE_LINE_W = (2 ** CACHE_LINE_OFF_ADDR_W) * 8;
    localparam int PTR_W        = $clog2(STQ_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t state;

    logic [PTR_W:0]        head;
    logic [PTR_W:0]        tail;
    logic [PTR_W:0]        count;
    logic [PTR_W-1:0]      head_idx;
    logic [PTR_W-1:0]      tail_idx;

    logic [ADDR_WIDTH-1:0] addr_q [STQ_DEPTH];
    logic [DATA_WIDTH-1:0] data_q [STQ_DEPTH];
    logic [3:0]            strb_q [STQ_DEPTH];
    logic [2:0]            type_q [STQ_DEPTH];

    logic                    full;
    logic                    empty;
    logic                    issue;
    logic                    push;
    logic                    merge_hit;
    logic                    inflight;
    logic                    ld_hit_c;
    logic [STQ_DEPTH-1:0]    entry_live;
    logic                    unused_ld_bits;

    logic                    pwr_req_q;
    logic [ADDR_WIDTH-1:0]   pwaddr_q;
    logic [CACHE_LINE_W-1:0] pwdata_q;
    logic [3:0]              pwstrb_q;
    logic [2:0]              pwtype_q;

    assign head_idx = head[PTR_W-1:0];
    assign tail_idx = tail[PTR_W-1:0];
    assign count    = tail - head;
    assign full     = (head_idx == tail_idx) && (head[PTR_W] != tail[PTR_W]);
    assign empty    = (head == tail);

`ifdef YSYX_23060025_STQ_MERGE_EN
    logic [PTR_W-1:0]      last_idx;
    logic [DATA_WIDTH-1:0] merged_data;

    // Coalescing never touches the head entry, so it can't race the entry being issued.
    assign last_idx  = tail_idx - 1'b1;
    assign merge_hit = (|count[PTR_W:1]) &&
                       (addr_q[last_idx][ADDR_WIDTH-1:2] == sq.in_addr[ADDR_WIDTH-1:2]);

    always_comb begin
        merged_data = data_q[last_idx];
        for (int b = 0; b < 4; b++) begin
            if (sq.in_strb[b]) merged_data[b*8 +: 8] = sq.in_data[b*8 +: 8];
        end
    end
`else
    assign merge_hit = 1'b0;
`endif

    assign push  = sq.in_valid && !full && !merge_hit;
    assign issue = !empty && sq.out_pwrdy && (state == S_IDLE || state == S_WAIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push)  tail <= tail + 1'b1;
            if (issue) head <= head + 1'b1;
        end
    end

    // Entry storage is deliberately left unreset; validity comes only from head/tail.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_q[tail_idx] <= sq.in_addr;
            data_q[tail_idx] <= sq.in_data;
            strb_q[tail_idx] <= sq.in_strb;
            type_q[tail_idx] <= sq.in_type;
        end
`ifdef YSYX_23060025_STQ_MERGE_EN
        else if (sq.in_valid && merge_hit) begin
            addr_q[last_idx] <= {sq.in_addr[ADDR_WIDTH-1:2], 2'b00};
            data_q[last_idx] <= merged_data;
            strb_q[last_idx] <= strb_q[last_idx] | sq.in_strb;
            type_q[last_idx] <= 3'b010;
        end
`endif
    end

    // Issue decision uses only registered state and out_pwrdy, keeping req a pure flop output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            pwr_req_q <= 1'b0;
            pwaddr_q  <= '0;
            pwdata_q  <= '0;
            pwstrb_q  <= '0;
            pwtype_q  <= '0;
        end else begin
            pwr_req_q <= 1'b0;
            case (state)
                S_IDLE:  if (issue) state <= S_REQ;
                S_REQ:   state <= S_WAIT;
                S_WAIT: begin
                    if (issue)              state <= S_REQ;
                    else if (sq.out_pwrdy)  state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (issue) begin
                pwr_req_q <= 1'b1;
                pwaddr_q  <= addr_q[head_idx];
                pwdata_q  <= CACHE_LINE_W'(data_q[head_idx]);
                pwstrb_q  <= strb_q[head_idx];
                pwtype_q  <= type_q[head_idx];
            end
        end
    end

    always_comb begin
        entry_live = '0;
        for (int i = 0; i < STQ_DEPTH; i++) begin
            entry_live[i] = ({1'b0, PTR_W'(i) - head_idx} < count);
        end
    end

    assign inflight = (state == S_REQ) || (state == S_WAIT && !sq.out_pwrdy);

    always_comb begin
        ld_hit_c = 1'b0;
        for (int i = 0; i < STQ_DEPTH; i++) begin
            if (entry_live[i] && addr_q[i][ADDR_WIDTH-1:2] == sq.ld_addr[ADDR_WIDTH-1:2])
                ld_hit_c = 1'b1;
        end
        if (inflight && pwaddr_q[ADDR_WIDTH-1:2] == sq.ld_addr[ADDR_WIDTH-1:2])
            ld_hit_c = 1'b1;
    end

    assign unused_ld_bits = ^sq.ld_addr[1:0];

    assign sq.in_ready    = !full || merge_hit;
    assign sq.ld_hit      = ld_hit_c;
    assign sq.sq_idle     = empty && (state != S_REQ) && sq.out_pwrdy;
    assign sq.out_pwr_req = pwr_req_q;
    assign sq.out_pwaddr  = pwaddr_q;
    assign sq.out_pwdata  = pwdata_q;
    assign sq.out_pwstrb  = pwstrb_q;
    assign sq.out_pwtype  = pwtype_q;

endmodule

// File: tb/tb_ysyx_23060025_store_queue.sv
// Scoreboard bench for the store queue: a FIFO reference model predicts every issued store,
// plus directed latency, full/refuse, load-hazard, reset and (when enabled) coalescing cases.
`timescale 1ns/1ps
`ifndef MACRO_CACHE_LINE_OFF_ADDR_W
`define MACRO_CACHE_LINE_OFF_ADDR_W 4
`endif

module tb_ysyx_23060025_store_queue;
    localparam int CL_W = (2 ** `MACRO_CACHE_LINE_OFF_ADDR_W) * 8;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  typ;
    } store_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic wb_enable = 1'b1;
    logic random_mode = 1'b0;
    int   wb_busy = 0;

    int vectors = 0;
    int miscompares = 0;
    int req_count = 0;

    store_t model_q[$];
    store_t mon_exp;
    logic [31:0] last_addr;
    logic [31:0] last_data;
    logic [3:0]  last_strb;
    logic [2:0]  last_type;

    always #5 clock = ~clock;

    ysyx_23060025_store_queue_if #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .CACHE_LINE_W(CL_W)
    ) sq_if ();

    ysyx_23060025_store_queue #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .STQ_DEPTH(4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .sq    (sq_if)
    );

    // Write buffer: ready drops the cycle it sees a request, then stays busy a few cycles.
    assign sq_if.out_pwrdy = wb_enable && !sq_if.out_pwr_req && (wb_busy == 0);

    always @(posedge clock) begin
        if (sq_if.out_pwr_req) wb_busy <= $urandom_range(0, 3);
        else if (wb_busy != 0) wb_busy <= wb_busy - 1;
    end

    initial begin
        forever begin
            @(negedge clock);
            if (random_mode) wb_enable = ($urandom_range(0, 9) < 7);
        end
    end

    task automatic check_output(input string name, input logic [255:0] actual, input logic [255:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every request pulse must match the oldest store the model still holds.
    always @(negedge clock) begin
        if (!reset && sq_if.out_pwr_req) begin
            req_count++;
            last_addr = sq_if.out_pwaddr;
            last_data = sq_if.out_pwdata[31:0];
            last_strb = sq_if.out_pwstrb;
            last_type = sq_if.out_pwtype;
            if (model_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_issue: got addr 0x%08h, required no issue", sq_if.out_pwaddr);
            end else begin
                mon_exp = model_q.pop_front();
                check_output("issue_addr", sq_if.out_pwaddr, mon_exp.addr);
                check_output("issue_data", sq_if.out_pwdata, mon_exp.data);
                check_output("issue_strb", sq_if.out_pwstrb, mon_exp.strb);
                check_output("issue_type", sq_if.out_pwtype, mon_exp.typ);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the store is taken.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] s, input logic [2:0] t);
        int     waited;
        logic   exp_ready;
        logic   exp_merge;
        store_t ent;
        waited = 0;
        exp_ready = 1'b0;
        exp_merge = 1'b0;
        sq_if.in_valid = 1'b1;
        sq_if.in_addr  = a;
        sq_if.in_data  = d;
        sq_if.in_strb  = s;
        sq_if.in_type  = t;
        forever begin
            #1;
            exp_merge = 1'b0;
`ifdef YSYX_23060025_STQ_MERGE_EN
            if (model_q.size() >= 2)
                exp_merge = (model_q[model_q.size()-1].addr[31:2] == a[31:2]);
`endif
            exp_ready = (model_q.size() < 4) || exp_merge;
            check_output("in_ready", sq_if.in_ready, exp_ready);
            @(posedge clock);
            if (exp_ready) break;
            waited++;
            if (waited > 300) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL push_timeout: got no acceptance, required acceptance within 300 cycles");
                break;
            end
            @(negedge clock);
        end
        if (exp_ready) begin
            if (exp_merge) begin
                ent = model_q[model_q.size()-1];
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) ent.data[b*8 +: 8] = d[b*8 +: 8];
                end
                ent.strb = ent.strb | s;
                ent.typ  = 3'b010;
                ent.addr = {a[31:2], 2'b00};
                model_q[model_q.size()-1] = ent;
            end else begin
                ent = '{a, d, s, t};
                model_q.push_back(ent);
            end
        end
        @(negedge clock);
        sq_if.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int cycles;
        cycles = 0;
        wb_enable = 1'b1;
        while (model_q.size() != 0 && cycles < 1000) begin
            @(negedge clock);
            cycles++;
        end
        @(negedge clock);
        #1;
        while (wb_busy != 0 && cycles < 1000) begin
            @(negedge clock);
            #1;
            cycles++;
        end
        if (cycles >= 1000) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain_timeout: got %0d stores pending, required 0", model_q.size());
        end
        check_output("sq_idle_drained", sq_if.sq_idle, 1'b1);
    endtask

    task automatic random_store();
        logic [31:0] a;
        logic [3:0]  s;
        logic [2:0]  t;
        t = 3'($urandom_range(0, 2));
        a = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 2);
        case (t)
            3'b000: begin
                a[1:0] = 2'($urandom_range(0, 3));
                s = 4'b0001 << a[1:0];
            end
            3'b001: begin
                a[1:0] = {1'($urandom_range(0, 1)), 1'b0};
                s = 4'b0011 << a[1:0];
            end
            default: s = 4'hF;
        endcase
        apply_stimulus(a, $urandom(), s, t);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r0;
        sq_if.in_valid = 1'b0;
        sq_if.in_addr  = '0;
        sq_if.in_data  = '0;
        sq_if.in_strb  = '0;
        sq_if.in_type  = '0;
        sq_if.ld_addr  = '0;

        repeat (2) @(negedge clock);
        #1;
        check_output("rst_in_ready", sq_if.in_ready, 1'b1);
        check_output("rst_ld_hit", sq_if.ld_hit, 1'b0);
        check_output("rst_req", sq_if.out_pwr_req, 1'b0);
        check_output("rst_sq_idle", sq_if.sq_idle, 1'b1);
        check_output("rst_pwaddr", sq_if.out_pwaddr, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] single store latency");
        apply_stimulus(32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 3'b010);
        #1;
        check_output("latency_cycle1_req", sq_if.out_pwr_req, 1'b0);
        @(negedge clock);
        #1;
        check_output("latency_cycle2_req", sq_if.out_pwr_req, 1'b1);
        wait_drain();

        $display("[TB] fill with write buffer stalled");
        wb_enable = 1'b0;
        for (int i = 0; i < 4; i++)
            apply_stimulus(32'h8000_1000 + 32'(i * 4), $urandom(), 4'hF, 3'b010);
        sq_if.in_valid = 1'b1;
        sq_if.in_addr  = 32'h8000_2000;
        #1;
        check_output("ready_full", sq_if.in_ready, 1'b0);
        @(negedge clock);
        #1;
        check_output("ready_full_hold", sq_if.in_ready, 1'b0);
        sq_if.in_valid = 1'b0;
        r0 = req_count;
        wait_drain();
        check_output("burst_issue_count", 32'(req_count - r0), 32'd4);

        $display("[TB] full queue with pop in same cycle");
        wb_enable = 1'b0;
        for (int i = 0; i < 4; i++)
            apply_stimulus(32'h8000_3000 + 32'(i * 4), $urandom(), 4'hF, 3'b010);
        r0 = req_count;
        sq_if.in_valid = 1'b1;
        sq_if.in_addr  = 32'h8000_3100;
        wb_enable = 1'b1;
        #1;
        check_output("ready_full_issue", sq_if.in_ready, 1'b0);
        @(negedge clock);
        sq_if.in_valid = 1'b0;
        #1;
        check_output("ready_after_pop", sq_if.in_ready, 1'b1);
        wait_drain();
        check_output("refused_issue_count", 32'(req_count - r0), 32'd4);

        $display("[TB] load hazard");
        wb_enable = 1'b0;
        apply_stimulus(32'h8000_0010, 32'h1234_5678, 4'hF, 3'b010);
        sq_if.ld_addr = 32'h8000_0013;
        #1;
        check_output("ld_hit_queued", sq_if.ld_hit, 1'b1);
        sq_if.ld_addr = 32'h8000_0014;
        #1;
        check_output("ld_miss_queued", sq_if.ld_hit, 1'b0);
        sq_if.ld_addr = 32'h8000_0013;
        wb_enable = 1'b1;
        @(negedge clock);
        wb_enable = 1'b0;
        #1;
        check_output("ld_hit_req", sq_if.ld_hit, 1'b1);
        @(negedge clock);
        #1;
        check_output("ld_hit_wait", sq_if.ld_hit, 1'b1);
        sq_if.ld_addr = 32'h8000_0014;
        #1;
        check_output("ld_miss_wait", sq_if.ld_hit, 1'b0);
        wait_drain();
        sq_if.ld_addr = 32'h8000_0013;
        #1;
        check_output("ld_clear_after_drain", sq_if.ld_hit, 1'b0);
        sq_if.ld_addr = '0;

        $display("[TB] random traffic");
        random_mode = 1'b1;
        for (int n = 0; n < 120; n++) begin
            random_store();
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        random_mode = 1'b0;
        wait_drain();

        $display("[TB] reset with stores pending");
        wb_enable = 1'b0;
        for (int i = 0; i < 4; i++)
            apply_stimulus(32'h8000_4000 + 32'(i * 4), $urandom(), 4'hF, 3'b010);
        sq_if.ld_addr = 32'h8000_4008;
        wb_enable = 1'b1;
        @(negedge clock);
        wb_enable = 1'b0;
        @(negedge clock);
        #1;
        check_output("ld_hit_pre_reset", sq_if.ld_hit, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check_output("async_rst_req", sq_if.out_pwr_req, 1'b0);
        check_output("async_rst_in_ready", sq_if.in_ready, 1'b1);
        check_output("async_rst_ld_hit", sq_if.ld_hit, 1'b0);
        check_output("async_rst_sq_idle", sq_if.sq_idle, sq_if.out_pwrdy);
        check_output("async_rst_pwaddr", sq_if.out_pwaddr, 32'h0);
        check_output("async_rst_pwstrb", sq_if.out_pwstrb, 4'h0);
        model_q.delete();
        @(negedge clock);
        reset = 1'b0;
        wb_enable = 1'b1;
        r0 = req_count;
        repeat (20) @(negedge clock);
        #1;
        check_output("no_issue_after_reset", 32'(req_count - r0), 32'd0);
        check_output("idle_after_reset", sq_if.sq_idle, 1'b1);
        sq_if.ld_addr = '0;

`ifdef YSYX_23060025_STQ_MERGE_EN
        $display("[TB] store coalescing");
        wb_enable = 1'b0;
        apply_stimulus(32'h0000_0100, 32'h0000_0011, 4'b0001, 3'b000);
        apply_stimulus(32'h0000_0206, 32'h00AA_0000, 4'b0100, 3'b000);
        apply_stimulus(32'h0000_0207, 32'hBB00_0000, 4'b1000, 3'b000);
        r0 = req_count;
        wait_drain();
        check_output("merge_issue_count", 32'(req_count - r0), 32'd2);
        check_output("merge_addr", last_addr, 32'h0000_0204);
        check_output("merge_data", last_data, 32'hBBAA_0000);
        check_output("merge_strb", last_strb, 4'b1100);
        check_output("merge_type", last_type, 3'b010);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
